decode_alu_stage: RTL and testbench
===================================

# decode_alu_stage

Registered, flow-controlled decode stage for RV32I/RV64I integer ALU instructions (OP-IMM and OP). It accepts raw 32-bit instruction words over a valid/ready handshake and presents register indices, sign-extended immediate and ALU control code to the execute stage one cycle later. A 2-entry skid buffer keeps full throughput under backpressure. It replaces the combinational immediate-only decoder; ALU codes come from `processor_defines.sv`.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64; sets immediate width and shift-amount legality.
- ALU_CTRL_W, 5, width of alu_control; must match `processor_defines.sv`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage can accept a word this cycle.
- in_instr  in  32  raw instruction.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  execute stage accepts record.
- rs1, rs2, rd  out  5 each  register indices; rs2 = 0 for OP-IMM.
- imm  out  XLEN  sign-extended I-immediate; 0 for OP.
- is_imm  out  1  1 = OP-IMM, 0 = OP.
- alu_control  out  ALU_CTRL_W  ALU operation code.
- illegal  out  1  record is an illegal/unsupported encoding.
- illegal_cnt  out  16  saturating count of illegal records accepted.

## Operation
- Decode is combinational on in_instr; result written into the output register on accept (in_valid && in_ready).
- Opcode 7'h13 (OP-IMM): func3 0 ADDI, 2 SLTI, 3 SLTIU, 4 XORI, 6 ORI, 7 ANDI; 1 SLLI; 5 SRLI/SRAI.
- Shift legality: XLEN=32 requires imm[11:5] = 7'h00 (SLLI/SRLI) or 7'h20 (SRAI). XLEN=64 checks imm[11:6] only (6'h00 / 6'h10); imm[5] is shamt.
- Opcode 7'h33 (OP): func7 7'h00 gives ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by func3; func7 7'h20 legal only for func3 0 (SUB) and 5 (SRA).
- Any other opcode, func7 or shift encoding: alu_control = `ALU_NOP`; illegal per Configuration.
- Fields never depend on legality: rd = [11:7], rs1 = [19:15], rs2 = [24:20] (OP only), imm = sign-extend([31:20]) (OP-IMM only).
- Skid buffer: main register feeds outputs; when out_valid && !out_ready and a word is accepted, it lands in the skid entry. in_ready = !skid_full (registered). On output pop, the skid entry moves to main; skid_full clears.
- Buffer states: EMPTY, ONE (main only), FULL (main + skid). Transitions:
  - EMPTY to ONE on accept.
  - ONE to FULL on accept without pop.
  - ONE to EMPTY on pop without accept.
  - ONE to ONE on simultaneous accept and pop.
  - FULL to ONE on pop; no accept possible in FULL.
- illegal_cnt increments on accept of an illegal word; it saturates at 16'hFFFF.

## Timing
- Latency 1 cycle: accepted on edge N, visible on outputs after edge N; out_valid high from that edge.
- Throughput 1/cycle while out_ready = 1.
- out_valid never drops without a pop. Record fields are stable while out_valid && !out_ready.
- in_ready falls the cycle after the skid entry fills and rises the cycle after it drains.
- Reset (any time, including mid-transfer): out_valid = 0, buffer EMPTY, in_ready = 1, all record fields 0, alu_control = `ALU_NOP`, illegal = 0, illegal_cnt = 0. Buffered records are discarded.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: illegal reflects decode legality and illegal_cnt counts illegal accepts.
- DECODE_ILLEGAL_TRAP_EN undefined: illegal and illegal_cnt tied to 0, and the counter logic is removed. Illegal words still decode to `ALU_NOP`.

## Test plan
- XLEN=32, in_instr 0xFFF10093, out_ready = 1: next cycle rd = 1, rs1 = 2, imm = 0xFFFFFFFF, `ADDI`, is_imm = 1, illegal = 0.
- in_instr 0x40335293: `SRAI`, rd = 5, rs1 = 6, imm = 0x00000403. Then 0x402081B3: `SUB`, rd = 3, rs1 = 1, rs2 = 2, is_imm = 0.
- in_instr 0x02009093: with XLEN=32 (macro defined), illegal = 1, `ALU_NOP`, illegal_cnt = 1. With XLEN=64, `SLLI`, illegal = 0.
- Backpressure: out_ready = 0, three back-to-back words. The first two are held, in_ready drops after the second, and the third waits. Raising out_ready pops all three in order, one per cycle, with no loss or duplicates.
- Simultaneous accept and pop in ONE state for 10 cycles: out_valid stays 1 and in_ready stays 1.
- Reset asserted in FULL state: outputs go to reset values immediately. After release, the first new word appears one cycle after acceptance.

Source files
------------

// File: rtl/decode_alu_stage.sv
// Registered RV32I/RV64I OP/OP-IMM decode stage with a 2-entry skid buffer on the output.
// Optional feature: DECODE_ILLEGAL_TRAP_EN enables the illegal flag and the saturating illegal counter.
//
// state   | meaning
// --------+---------------------------------------------
// S_EMPTY | no record held, out_valid low
// S_ONE   | main register holds a record
// S_FULL  | main and skid both hold records, in_ready low

`timescale 1ns/1ps

`ifndef ALU_NOP
`define ALU_NOP  0
`define ALU_ADD  1
`define ALU_SUB  2
`define ALU_SLL  3
`define ALU_SLT  4
`define ALU_SLTU 5
`define ALU_XOR  6
`define ALU_SRL  7
`define ALU_SRA  8
`define ALU_OR   9
`define ALU_AND  10
`endif

module decode_alu_stage #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [XLEN-1:0]       imm,
    output logic                  is_imm,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic [15:0]           illegal_cnt
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [ALU_CTRL_W-1:0] ALU_NOP_C  = ALU_CTRL_W'(`ALU_NOP);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD_C  = ALU_CTRL_W'(`ALU_ADD);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB_C  = ALU_CTRL_W'(`ALU_SUB);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL_C  = ALU_CTRL_W'(`ALU_SLL);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT_C  = ALU_CTRL_W'(`ALU_SLT);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU_C = ALU_CTRL_W'(`ALU_SLTU);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR_C  = ALU_CTRL_W'(`ALU_XOR);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL_C  = ALU_CTRL_W'(`ALU_SRL);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA_C  = ALU_CTRL_W'(`ALU_SRA);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR_C   = ALU_CTRL_W'(`ALU_OR);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND_C  = ALU_CTRL_W'(`ALU_AND);

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef struct packed {
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [XLEN-1:0]       imm;
        logic                  is_imm;
        logic [ALU_CTRL_W-1:0] alu;
        logic                  illegal;
    } rec_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    rec_t   r_main, r_skid, w_dec;
    logic   r_in_ready;
    logic   w_accept, w_pop;
    logic   w_load_main_in, w_load_main_skid, w_load_skid;
    logic   w_legal, w_shift_lo, w_shift_hi;
    logic [ALU_CTRL_W-1:0] w_alu_raw;
    logic [6:0] w_opcode, w_func7;
    logic [2:0] w_func3;

    assign w_opcode = in_instr[6:0];
    assign w_func3  = in_instr[14:12];
    assign w_func7  = in_instr[31:25];

    // RV64 shamt is six bits wide, so only imm[11:6] carries the shift-type encoding.
    always_comb begin
        if (RV64) begin
            w_shift_lo = (in_instr[31:26] == 6'h00);
            w_shift_hi = (in_instr[31:26] == 6'h10);
        end else begin
            w_shift_lo = (w_func7 == 7'h00);
            w_shift_hi = (w_func7 == 7'h20);
        end
    end

    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b0;
        w_alu_raw = ALU_NOP_C;
        w_dec.rd  = in_instr[11:7];
        w_dec.rs1 = in_instr[19:15];
        case (w_opcode)
            OPC_OP_IMM: begin
                w_dec.is_imm = 1'b1;
                w_dec.imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                w_legal      = 1'b1;
                case (w_func3)
                    3'd0: w_alu_raw = ALU_ADD_C;
                    3'd1: begin
                        w_alu_raw = ALU_SLL_C;
                        w_legal   = w_shift_lo;
                    end
                    3'd2: w_alu_raw = ALU_SLT_C;
                    3'd3: w_alu_raw = ALU_SLTU_C;
                    3'd4: w_alu_raw = ALU_XOR_C;
                    3'd5: begin
                        w_alu_raw = w_shift_hi ? ALU_SRA_C : ALU_SRL_C;
                        w_legal   = w_shift_lo | w_shift_hi;
                    end
                    3'd6: w_alu_raw = ALU_OR_C;
                    default: w_alu_raw = ALU_AND_C;
                endcase
            end
            OPC_OP: begin
                w_dec.rs2 = in_instr[24:20];
                if (w_func7 == 7'h00) begin
                    w_legal = 1'b1;
                    case (w_func3)
                        3'd0: w_alu_raw = ALU_ADD_C;
                        3'd1: w_alu_raw = ALU_SLL_C;
                        3'd2: w_alu_raw = ALU_SLT_C;
                        3'd3: w_alu_raw = ALU_SLTU_C;
                        3'd4: w_alu_raw = ALU_XOR_C;
                        3'd5: w_alu_raw = ALU_SRL_C;
                        3'd6: w_alu_raw = ALU_OR_C;
                        default: w_alu_raw = ALU_AND_C;
                    endcase
                end else if (w_func7 == 7'h20) begin
                    if (w_func3 == 3'd0) begin
                        w_alu_raw = ALU_SUB_C;
                        w_legal   = 1'b1;
                    end else if (w_func3 == 3'd5) begin
                        w_alu_raw = ALU_SRA_C;
                        w_legal   = 1'b1;
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
        w_dec.alu = w_legal ? w_alu_raw : ALU_NOP_C;
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_dec.illegal = ~w_legal;
`else
        w_dec.illegal = 1'b0;
`endif
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_main      <= '0;
            r_main.alu  <= ALU_NOP_C;
            r_skid      <= '0;
            r_skid.alu  <= ALU_NOP_C;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
            if (w_load_main_in) begin
                r_main <= w_dec;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic [15:0] r_illegal_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= 16'h0000;
        end else if (w_accept && w_dec.illegal && (r_illegal_cnt != 16'hFFFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 16'h0001;
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`else
    assign illegal_cnt = 16'h0000;
`endif

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != S_EMPTY);
    assign rs1         = r_main.rs1;
    assign rs2         = r_main.rs2;
    assign rd          = r_main.rd;
    assign imm         = r_main.imm;
    assign is_imm      = r_main.is_imm;
    assign alu_control = r_main.alu;
    assign illegal     = r_main.illegal;

endmodule

// File: tb/tb_decode_alu_stage.sv
// Directed-vector bench for decode_alu_stage: decode fields, skid-buffer flow control and reset.
// Expected illegal flag/count follow whether DECODE_ILLEGAL_TRAP_EN is defined for the build.

`timescale 1ns/1ps

module tb_decode_alu_stage;

    localparam logic [4:0] A_NOP  = 5'd0;
    localparam logic [4:0] A_ADD  = 5'd1;
    localparam logic [4:0] A_SUB  = 5'd2;
    localparam logic [4:0] A_SLL  = 5'd3;
    localparam logic [4:0] A_SLTU = 5'd5;
    localparam logic [4:0] A_SRA  = 5'd8;
    localparam logic [4:0] A_AND  = 5'd10;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, is_imm, illegal;
    logic [4:0]  rs1, rs2, rd, alu_control;
    logic [31:0] imm;
    logic [15:0] illegal_cnt;

    logic        in_ready64, out_valid64, is_imm64, illegal64;
    logic [4:0]  rs1_64, rs2_64, rd_64, alu64;
    logic [63:0] imm64;
    logic [15:0] illegal_cnt64;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_alu_stage #(.XLEN(32), .ALU_CTRL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .is_imm(is_imm),
        .alu_control(alu_control), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    decode_alu_stage #(.XLEN(64), .ALU_CTRL_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
        .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .imm(imm64), .is_imm(is_imm64),
        .alu_control(alu64), .illegal(illegal64), .illegal_cnt(illegal_cnt64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rec(input string tag, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                           input logic [4:0] e_rs2, input logic [31:0] e_imm, input logic e_is_imm,
                           input logic [4:0] e_alu, input logic e_ill);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".rd"}, 64'(rd), 64'(e_rd));
        chk({tag, ".rs1"}, 64'(rs1), 64'(e_rs1));
        chk({tag, ".rs2"}, 64'(rs2), 64'(e_rs2));
        chk({tag, ".imm"}, 64'(imm), 64'(e_imm));
        chk({tag, ".is_imm"}, 64'(is_imm), 64'(e_is_imm));
        chk({tag, ".alu"}, 64'(alu_control), 64'(e_alu));
        chk({tag, ".illegal"}, 64'(illegal), 64'(e_ill));
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.rd", 64'(rd), 64'd0);
        chk("rst.imm", 64'(imm), 64'd0);
        chk("rst.alu", 64'(alu_control), 64'(A_NOP));
        chk("rst.cnt", 64'(illegal_cnt), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Decode vectors at full throughput
        in_valid = 1'b1;
        in_instr = 32'hFFF10093; cyc();
        chk_rec("addi", 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, A_ADD, 1'b0);
        in_instr = 32'h40335293; cyc();
        chk_rec("srai", 5'd5, 5'd6, 5'd0, 32'h00000403, 1'b1, A_SRA, 1'b0);
        in_instr = 32'h402081B3; cyc();
        chk_rec("sub", 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, A_SUB, 1'b0);
        in_instr = 32'h02009093; cyc();
        chk_rec("slli32", 5'd1, 5'd1, 5'd0, 32'h00000020, 1'b1, A_NOP, TRAP);
        chk("slli32.cnt", 64'(illegal_cnt), 64'(TRAP ? 1 : 0));
        chk("slli64.alu", 64'(alu64), 64'(A_SLL));
        chk("slli64.illegal", 64'(illegal64), 64'd0);
        chk("slli64.imm", imm64, 64'h20);
        in_instr = 32'h40209133; cyc();
        chk_rec("op_bad_f7", 5'd2, 5'd1, 5'd2, 32'h0, 1'b0, A_NOP, TRAP);
        chk("op_bad_f7.cnt", 64'(illegal_cnt), 64'(TRAP ? 2 : 0));
        in_instr = 32'h00000073; cyc();
        chk_rec("bad_opc", 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, A_NOP, TRAP);
        chk("bad_opc.cnt", 64'(illegal_cnt), 64'(TRAP ? 3 : 0));
        in_instr = 32'h003272B3; cyc();
        chk_rec("and", 5'd5, 5'd4, 5'd3, 32'h0, 1'b0, A_AND, 1'b0);
        in_instr = 32'h7FF1B213; cyc();
        chk_rec("sltiu", 5'd4, 5'd3, 5'd0, 32'h000007FF, 1'b1, A_SLTU, 1'b0);
        chk("sltiu.cnt", 64'(illegal_cnt), 64'(TRAP ? 3 : 0));
        in_valid = 1'b0; cyc();
        chk("drain.valid", 64'(out_valid), 64'd0);

        // Backpressure: two held, third waits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093; cyc();
        chk("bp.a.in_ready", 64'(in_ready), 64'd1);
        in_instr  = 32'h00200113; cyc();
        chk("bp.b.in_ready", 64'(in_ready), 64'd0);
        chk("bp.b.rd", 64'(rd), 64'd1);
        in_instr  = 32'h00300193; cyc();
        chk("bp.c.in_ready", 64'(in_ready), 64'd0);
        chk("bp.hold1.rd", 64'(rd), 64'd1);
        cyc();
        chk("bp.hold2.rd", 64'(rd), 64'd1);
        chk("bp.hold2.imm", 64'(imm), 64'd1);
        chk("bp.hold2.valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1; cyc();
        chk("bp.pop1.rd", 64'(rd), 64'd2);
        chk("bp.pop1.in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp.pop2.rd", 64'(rd), 64'd3);
        chk("bp.pop2.imm", 64'(imm), 64'd3);
        cyc();
        chk("bp.pop3.valid", 64'(out_valid), 64'd0);

        // Sustained accept + pop in ONE
        in_valid = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            in_instr = {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};
            cyc();
            chk($sformatf("stream%0d.rd", i), 64'(rd), 64'(i));
            chk($sformatf("stream%0d.valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0; cyc();

        // Reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093; cyc();
        in_instr  = 32'h02009093; cyc();
        chk("full.in_ready", 64'(in_ready), 64'd0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rstfull.valid", 64'(out_valid), 64'd0);
        chk("rstfull.in_ready", 64'(in_ready), 64'd1);
        chk("rstfull.rd", 64'(rd), 64'd0);
        chk("rstfull.imm", 64'(imm), 64'd0);
        chk("rstfull.alu", 64'(alu_control), 64'(A_NOP));
        chk("rstfull.cnt", 64'(illegal_cnt), 64'd0);
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("postrst.idle", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_instr = 32'h7FF1B213; cyc();
        in_valid = 1'b0;
        chk_rec("postrst", 5'd4, 5'd3, 5'd0, 32'h000007FF, 1'b1, A_SLTU, 1'b0);
        cyc();
        chk("postrst.drain", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
